// File: rtl/ram_port_bist_initiator.sv
// RAM port self-test initiator: fills N words with an LFSR pattern from a base
// address, reads them back, and counts mismatches against the regenerated pattern.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// FILL  | one write per cycle at base+idx
// READ  | one read per cycle at base+idx, expected data queued for compare
// DRAIN | no new reads; waiting for in-flight compares to retire
// DONE  | results held; a new start reruns
module ram_port_bist_initiator #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       seed,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [2:0] {IDLE, FILL, READ, DRAIN, DONE} state_t;

  // The oldest pipeline slot is the one compared this cycle; it does not block DONE.
  localparam logic [READ_LAT-1:0] LAST_MASK = READ_LAT'(1) << (READ_LAT - 1);

  state_t state, stateNext;

  logic [31:0]       seedR;
  logic [31:0]       lfsr;
  logic [31:0]       lfsrNext;
  logic [31:0]       seedEff;
  logic [ADDR_W-1:0] baseR;
  logic [ADDR_W:0]   cntR;
  logic [ADDR_W:0]   idx;
  logic [DATA_W-1:0] dinHold;
  logic              accept;
  logic              lastIdx;
  logic              drainEmpty;

  logic [READ_LAT-1:0] pipeValid;
  logic [DATA_W-1:0]   pipeData [READ_LAT];
  logic [ADDR_W-1:0]   pipeAddr [READ_LAT];
  logic                mismatch;
  logic [15:0]         errNext;

  assign seedEff    = (seed == 32'h0) ? 32'h1 : seed;
  assign lfsrNext   = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign lastIdx    = (idx == cntR - (ADDR_W + 1)'(1));
  assign drainEmpty = ((pipeValid & ~LAST_MASK) == '0);
  assign mismatch   = pipeValid[READ_LAT-1] && (mem_dout != pipeData[READ_LAT-1]);
  assign errNext    = (mismatch && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;

  // State register; reset returns to IDLE so mem_we drops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state decode and RAM port drive.
  always_comb begin
    stateNext = state;
    mem_we    = 1'b0;
    mem_addr  = baseR + idx[ADDR_W-1:0];
    mem_din   = dinHold;
    case (state)
      IDLE, DONE: begin
        if (start) stateNext = (count == '0) ? DRAIN : FILL;
      end
      FILL: begin
        mem_we  = 1'b1;
        mem_din = lfsr[DATA_W-1:0];
        if (lastIdx) stateNext = READ;
      end
      READ: begin
        if (lastIdx) stateNext = DRAIN;
      end
      DRAIN: begin
        if (drainEmpty) stateNext = DONE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Run parameters, address index and pattern generator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seedR   <= 32'h0;
      lfsr    <= 32'h0;
      baseR   <= '0;
      cntR    <= '0;
      idx     <= '0;
      dinHold <= '0;
    end else if (accept) begin
      seedR <= seedEff;
      lfsr  <= seedEff;
      baseR <= base_addr;
      cntR  <= count;
      idx   <= '0;
    end else if (state == FILL) begin
      dinHold <= lfsr[DATA_W-1:0];
      if (lastIdx) begin
        idx  <= '0;
        lfsr <= seedR;
      end else begin
        idx  <= idx + (ADDR_W + 1)'(1);
        lfsr <= lfsrNext;
      end
    end else if (state == READ) begin
      lfsr <= lfsrNext;
      if (!lastIdx) idx <= idx + (ADDR_W + 1)'(1);
    end
  end

  // Expected data/address travel alongside the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipeValid <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pipeData[i] <= '0;
        pipeAddr[i] <= '0;
      end
    end else begin
      pipeValid[0] <= (state == READ);
      pipeData[0]  <= lfsr[DATA_W-1:0];
      pipeAddr[0]  <= mem_addr;
      for (int i = 1; i < READ_LAT; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipeData[i]  <= pipeData[i-1];
        pipeAddr[i]  <= pipeAddr[i-1];
      end
    end
  end

  // Status and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 16'h0;
      first_err_addr <= '0;
    end else if (accept) begin
      busy           <= (count != '0);
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 16'h0;
      first_err_addr <= '0;
    end else begin
      err_count <= errNext;
      if (mismatch && (err_count == 16'h0)) first_err_addr <= pipeAddr[READ_LAT-1];
      if ((state == DRAIN) && drainEmpty) begin
        done <= 1'b1;
        busy <= 1'b0;
        pass <= (errNext == 16'h0);
      end
    end
  end

endmodule
